md5_search_ctrl: RTL and testbench

//  Sequences a brute-force search through the 64-stage MD5 round pipeline (chain of per-round

---
 rtl/md5_search_pkg.sv | 16 +
 rtl/md5_search_ctrl_if.sv | 40 ++++
 rtl/md5_tag_delay.sv | 44 ++++
 rtl/md5_search_ctrl.sv | 175 +++++++++++++++++
 tb/tb_md5_search_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/md5_search_pkg.sv
// Shared types and constants for the MD5 brute-force search controller.
package md5_search_pkg;

    localparam int         PIPE_LAT_DEF = 64;
    localparam int         CAND_W_DEF   = 40;
    localparam logic [7:0] PAD_BYTE     = 8'h80;
    localparam int         LEN_WORD_LSB = 448;
    localparam int         MATCH_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/md5_search_ctrl_if.sv
// Host and pipeline signals of md5_search_ctrl; MD5_SEARCH_CONTINUE_EN adds match_cnt.
interface md5_search_ctrl_if #(
    parameter int CAND_W = md5_search_pkg::CAND_W_DEF
);
    import md5_search_pkg::*;

    logic              start;
    logic              abort;
    logic [127:0]      target_digest;
    logic [CAND_W-1:0] range_base;
    logic [CAND_W-1:0] range_count;
    logic              pipe_valid;
    logic [511:0]      pipe_m;
    logic [127:0]      pipe_digest;
    logic              busy;
    logic              done;
    logic              found;
    logic [CAND_W-1:0] found_cand;
    logic [CAND_W-1:0] tested_count;
`ifdef MD5_SEARCH_CONTINUE_EN
    logic [MATCH_CNT_W-1:0] match_cnt;
`endif

    modport slave (
        input  start, abort, target_digest, range_base, range_count, pipe_digest,
`ifdef MD5_SEARCH_CONTINUE_EN
        output match_cnt,
`endif
        output pipe_valid, pipe_m, busy, done, found, found_cand, tested_count
    );

    modport master (
        output start, abort, target_digest, range_base, range_count, pipe_digest,
`ifdef MD5_SEARCH_CONTINUE_EN
        input  match_cnt,
`endif
        input  pipe_valid, pipe_m, busy, done, found, found_cand, tested_count
    );

endinterface

// File: rtl/md5_tag_delay.sv
// Fixed-latency {valid,cand} delay line matching the hash pipeline, with flush
// and a running count of valid entries still in flight.
module md5_tag_delay #(
    parameter int DEPTH = 64,
    parameter int W     = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [W-1:0]                 in_cand,
    output logic                         out_valid,
    output logic [W-1:0]                 out_cand,
    output logic [$clog2(DEPTH+1)-1:0]   inflight
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] vld_r;
    logic [W-1:0]     cand_r [DEPTH];
    logic [CNT_W-1:0] cnt_r;

    // Shift tags one stage per clock; flush drops everything including the incoming tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            cnt_r <= '0;
            for (int i = 0; i < DEPTH; i++) cand_r[i] <= '0;
        end else if (flush) begin
            vld_r <= '0;
            cnt_r <= '0;
            for (int i = 0; i < DEPTH; i++) cand_r[i] <= '0;
        end else begin
            vld_r     <= {vld_r[DEPTH-2:0], in_valid};
            cand_r[0] <= in_cand;
            for (int i = 1; i < DEPTH; i++) cand_r[i] <= cand_r[i-1];
            cnt_r     <= cnt_r + CNT_W'(in_valid) - CNT_W'(vld_r[DEPTH-1]);
        end
    end

    assign out_valid = vld_r[DEPTH-1];
    assign out_cand  = cand_r[DEPTH-1];
    assign inflight  = cnt_r;

endmodule

// File: rtl/md5_search_ctrl.sv
// Brute-force search sequencer for a fixed-latency MD5 pipeline.
// Define MD5_SEARCH_CONTINUE_EN to keep searching after a match and count matches.
module md5_search_ctrl
    import md5_search_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int CAND_W   = CAND_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    md5_search_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(PIPE_LAT + 1);

    state_t             state_r, state_s;
    logic [127:0]       target_r;
    logic [CAND_W-1:0]  next_cand_r, remain_r, issue_cand_s;
    logic               pipe_valid_r, done_r, found_r;
    logic [511:0]       pipe_m_r;
    logic [CAND_W-1:0]  found_cand_r, tested_r;
    logic               issue_s, load_s, done_s, flush_s, cmp_s, hit_s, stop_s, drain_last_s;
    logic               tag_valid_s;
    logic [CAND_W-1:0]  tag_cand_s;
    logic [CNT_W-1:0]   inflight_s;

    // Single-block MD5 padding: candidate bytes, 0x80 marker, 32-bit bit length
    function automatic logic [511:0] pad_block(input logic [CAND_W-1:0] cand);
        logic [511:0] blk;
        blk                      = '0;
        blk[CAND_W-1:0]          = cand;
        blk[CAND_W +: 8]         = PAD_BYTE;
        blk[LEN_WORD_LSB +: 32]  = 32'(CAND_W);
        return blk;
    endfunction

    md5_tag_delay #(.DEPTH(PIPE_LAT), .W(CAND_W)) u_tag (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_s),
        .in_valid  (pipe_valid_r),
        .in_cand   (pipe_m_r[CAND_W-1:0]),
        .out_valid (tag_valid_s),
        .out_cand  (tag_cand_s),
        .inflight  (inflight_s)
    );

    // abort discards a compare landing in the same cycle
    assign cmp_s        = tag_valid_s && (state_r != ST_IDLE) && !bus.abort;
    assign hit_s        = cmp_s && (bus.pipe_digest == target_r);
    assign drain_last_s = (inflight_s == CNT_W'(tag_valid_s));
`ifdef MD5_SEARCH_CONTINUE_EN
    assign stop_s = 1'b0;
`else
    assign stop_s = hit_s;
`endif

    // Next-state, issue and completion decisions
    always_comb begin
        state_s      = state_r;
        issue_s      = 1'b0;
        issue_cand_s = next_cand_r;
        load_s       = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    load_s = 1'b1;
                    if (bus.range_count == '0) begin
                        done_s = 1'b1;
                    end else begin
                        state_s      = ST_RUN;
                        issue_s      = 1'b1;
                        issue_cand_s = bus.range_base;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.abort || stop_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else if (remain_r == '0) begin
                    state_s = ST_DRAIN;
                end else begin
                    issue_s = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (bus.abort || stop_s || drain_last_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        flush_s = (state_r != ST_IDLE) && (state_s == ST_IDLE);
    end

    // FSM state, issue stream and latched search parameters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pipe_valid_r <= 1'b0;
            pipe_m_r     <= '0;
            next_cand_r  <= '0;
            remain_r     <= '0;
            target_r     <= '0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            pipe_valid_r <= issue_s;
            done_r       <= done_s;
            if (issue_s) begin
                pipe_m_r    <= pad_block(issue_cand_s);
                next_cand_r <= issue_cand_s + CAND_W'(1);
            end
            if (load_s) begin
                target_r <= bus.target_digest;
                remain_r <= bus.range_count - CAND_W'(1);
            end else if (issue_s) begin
                remain_r <= remain_r - CAND_W'(1);
            end
        end
    end

    // Match bookkeeping; found_cand only takes the first hit after a start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            found_r      <= 1'b0;
            found_cand_r <= '0;
            tested_r     <= '0;
        end else if (load_s) begin
            found_r      <= 1'b0;
            found_cand_r <= '0;
            tested_r     <= '0;
        end else begin
            if (cmp_s) tested_r <= tested_r + CAND_W'(1);
            if (hit_s && !found_r) begin
                found_r      <= 1'b1;
                found_cand_r <= tag_cand_s;
            end
        end
    end

`ifdef MD5_SEARCH_CONTINUE_EN
    logic [MATCH_CNT_W-1:0] match_cnt_r;

    // Saturating match counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt_r <= '0;
        end else if (load_s) begin
            match_cnt_r <= '0;
        end else if (hit_s && (match_cnt_r != {MATCH_CNT_W{1'b1}})) begin
            match_cnt_r <= match_cnt_r + MATCH_CNT_W'(1);
        end
    end

    assign bus.match_cnt = match_cnt_r;
`endif

    assign bus.pipe_valid   = pipe_valid_r;
    assign bus.pipe_m       = pipe_m_r;
    assign bus.busy         = (state_r != ST_IDLE);
    assign bus.done         = done_r;
    assign bus.found        = found_r;
    assign bus.found_cand   = found_cand_r;
    assign bus.tested_count = tested_r;

endmodule

// File: tb/tb_md5_search_ctrl.sv
// Bench for md5_search_ctrl: a behavioural MD5 pipeline stand-in plus a cycle-level
// reference of the search outcome derived from candidate indices and event cycles.
module tb_md5_search_ctrl;
    localparam int PL = 64;
    localparam int CW = 40;
`ifdef MD5_SEARCH_CONTINUE_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    md5_search_ctrl_if #(.CAND_W(CW)) bus ();
    md5_search_ctrl #(.PIPE_LAT(PL), .CAND_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] md5_k [64];
    int          md5_s [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    logic [128:0] ring [PL];
    int unsigned gcyc = 0;
    logic [127:0] run_tgt;
    bit           plant_en;
    logic [39:0]  plant_a, plant_b;

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] blk(input logic [39:0] c);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 5; i++) b[8*i +: 8] = c[8*i +: 8];
        b[40 +: 8]  = 8'h80;
        b[448 +: 32] = 32'd40;
        return b;
    endfunction

    function automatic logic [127:0] md5_of(input logic [511:0] m);
        logic [31:0] a, b, c, d, f, tmp;
        int g, sh;
        a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5*i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3*i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7*i) % 16; end
            sh  = md5_s[(i/16)*4 + (i%4)];
            tmp = a + f + md5_k[i] + m[32*g +: 32];
            a = d; d = c; c = b;
            b = b + ((tmp << sh) | (tmp >> (32 - sh)));
        end
        return {a + 32'h67452301, b + 32'hefcdab89, c + 32'h98badcfe, d + 32'h10325476};
    endfunction

    // planted candidates stand in for hash collisions so multiple matches can occur
    function automatic logic [127:0] digest_of(input logic [39:0] c);
        if (plant_en && (c == plant_a || c == plant_b)) return run_tgt;
        return md5_of(blk(c));
    endfunction

    function automatic logic [39:0] rnd40();
        return {8'($urandom), 32'($urandom)};
    endfunction

    // pipeline stand-in: record this cycle's issue, replay it PL cycles later
    always @(negedge clk) begin
        if (bus.pipe_valid === 1'b1) ring[gcyc % PL] = {1'b1, digest_of(bus.pipe_m[39:0])};
        else                         ring[gcyc % PL] = {1'b0, 128'h0};
    end

    always @(posedge clk) begin
        gcyc++;
        #1;
        if (ring[gcyc % PL][128]) bus.pipe_digest = ring[gcyc % PL][127:0];
        else if ($urandom_range(1) == 1) bus.pipe_digest = run_tgt;
        else bus.pipe_digest = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    end

    task automatic check_zero(input string tag);
        check_eq({tag, ".pipe_valid"}, bus.pipe_valid, 1'b0);
        check_eq({tag, ".pipe_m"}, bus.pipe_m, 512'h0);
        check_eq({tag, ".busy"}, bus.busy, 1'b0);
        check_eq({tag, ".done"}, bus.done, 1'b0);
        check_eq({tag, ".found"}, bus.found, 1'b0);
        check_eq({tag, ".found_cand"}, bus.found_cand, 40'h0);
        check_eq({tag, ".tested"}, bus.tested_count, 40'h0);
`ifdef MD5_SEARCH_CONTINUE_EN
        check_eq({tag, ".match_cnt"}, bus.match_cnt, 8'h0);
`endif
    endtask

    task automatic run_case(input string name, input logic [39:0] base, input int n,
                            input logic [127:0] tgt, input int abort_at, input int xstart_at);
        int e, tested, mcnt, k;
        bit aborted, fnd, exp_v;
        logic [39:0] fcand;
        bit hit [];
        run_tgt = tgt;
        hit = new[n];
        for (int i = 0; i < n; i++) hit[i] = (digest_of(base + 40'(i)) == tgt);
        e = (n == 0) ? 0 : PL + n;
        if (!CONT) begin
            for (int i = 0; i < n; i++) if (hit[i]) begin
                if (PL + 1 + i < e) e = PL + 1 + i;
                break;
            end
        end
        aborted = (n > 0) && (abort_at >= 1) && (abort_at <= e);
        if (aborted) e = abort_at;
        fnd = 1'b0; fcand = '0; tested = 0; mcnt = 0;

        @(posedge clk); #1;
        bus.start = 1'b1; bus.abort = 1'b0;
        bus.range_base = base; bus.range_count = 40'(n); bus.target_digest = tgt;

        for (int c = 1; c <= e + PL + 2; c++) begin
            @(posedge clk); #1;
            bus.start         = (c == xstart_at) && (c <= e);
            bus.abort         = (c == abort_at);
            bus.target_digest = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            bus.range_base    = rnd40();
            k = c - 1 - (PL + 1);
            if (k >= 0 && k < n && (c - 1) <= e && !(aborted && (c - 1) == e)) begin
                tested++;
                if (hit[k]) begin
                    if (!fnd) begin fnd = 1'b1; fcand = base + 40'(k); end
                    if (mcnt < 255) mcnt++;
                end
            end
            @(negedge clk);
            exp_v = (c <= n) && (c <= e);
            check_eq($sformatf("%s.valid@%0d", name, c), bus.pipe_valid, exp_v);
            check_eq($sformatf("%s.busy@%0d", name, c), bus.busy, c <= e);
            check_eq($sformatf("%s.done@%0d", name, c), bus.done, c == e + 1);
            check_eq($sformatf("%s.found@%0d", name, c), bus.found, fnd);
            check_eq($sformatf("%s.tested@%0d", name, c), bus.tested_count, 40'(tested));
            if (fnd) check_eq($sformatf("%s.fcand@%0d", name, c), bus.found_cand, fcand);
`ifdef MD5_SEARCH_CONTINUE_EN
            check_eq($sformatf("%s.mcnt@%0d", name, c), bus.match_cnt, 8'(mcnt));
`endif
            if (exp_v) begin
                check_eq($sformatf("%s.m@%0d", name, c), bus.pipe_m, blk(base + 40'(c - 1)));
                check_eq($sformatf("%s.pad@%0d", name, c), bus.pipe_m[47:40], 8'h80);
                check_eq($sformatf("%s.len@%0d", name, c), bus.pipe_m[479:448], 32'd40);
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        logic [39:0] b;
        int n, ab, xs;
        real r;
        for (int i = 0; i < 64; i++) begin
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            md5_k[i] = 32'(longint'($floor(r * 4294967296.0)));
        end
        for (int i = 0; i < PL; i++) ring[i] = '0;
        rst_n = 1'b0; plant_en = 1'b0; run_tgt = '0; plant_a = '0; plant_b = '0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.target_digest = '0;
        bus.range_base = '0; bus.range_count = '0; bus.pipe_digest = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset");

        run_case("hit7", 40'h0, 16, digest_of(40'd7), 0, 5);
        run_case("nohit", 40'h0, 16, {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)}, 0, 0);
        run_case("zero", 40'h0, 0, digest_of(40'd0), 0, 0);
        run_case("wrap", 40'hFF_FFFF_FFFE, 4, {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)}, 0, 0);
        b = rnd40();
        run_case("abort", b, 1000, digest_of(b + 40'd3), 20, 10);
        plant_en = 1'b1; plant_a = 40'd3; plant_b = 40'd9;
        run_case("multi", 40'h0, 16, {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)}, 0, 0);
        plant_en = 1'b0;

        for (int it = 0; it < 8; it++) begin
            b  = ($urandom_range(1) == 1) ? rnd40() : (40'hFF_FFFF_FFF0 + 40'($urandom_range(15)));
            n  = $urandom_range(40);
            ab = ($urandom_range(1) == 1) ? 0 : $urandom_range(n + 70, 1);
            xs = $urandom_range(n + 70, 1);
            plant_en = ($urandom_range(2) == 0);
            plant_a  = b + 40'($urandom_range(n + 2));
            plant_b  = b + 40'($urandom_range(n + 2));
            if (plant_en || $urandom_range(1) == 1)
                run_case($sformatf("rnd%0d", it), b, n,
                         {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)}, ab, xs);
            else
                run_case($sformatf("rnd%0d", it), b, n, digest_of(b + 40'($urandom_range(n + 3))), ab, xs);
        end
        plant_en = 1'b0;

        run_tgt = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
        @(posedge clk); #1;
        bus.start = 1'b1; bus.range_base = 40'h0; bus.range_count = 40'd100; bus.target_digest = run_tgt;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (69) @(posedge clk);
        #1;
        check_eq("midrst.busy_before", bus.busy, 1'b1);
        check_eq("midrst.tested_before", bus.tested_count, 40'd5);
        #1 rst_n = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("after_midrst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
